// File: rtl/fpga_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared definitions for the FPGA configuration loader: frame geometry,
// output image widths, the default frame start marker and the loader FSM
// state type. Imported by every file of the loader.
// ---------------------------------------------------------------------------
package fpga_cfg_pkg;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hF96A_C0DE;

    localparam int WORD_W    = 32;
    localparam int N_LUT     = 8;
    localparam int N_SB      = 7;
    localparam int LUT_W     = 33;
    localparam int SB_W      = 32;
    localparam int N_PAYLOAD = 16;
    localparam int CNT_W     = $clog2(N_PAYLOAD);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } cfg_state_t;

    // A LUT image is its 32-bit payload word with one extra top bit taken
    // from the shared high byte of the last payload word.
    function automatic logic [LUT_W-1:0] lutImage(input logic topBit,
                                                  input logic [WORD_W-1:0] word);
        return {topBit, word};
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// fpga_cfg_loader_if
// Valid/ready configuration stream into the loader.
//   in_data  : 32-bit configuration stream word (master -> slave)
//   in_valid : in_data is valid this cycle      (master -> slave)
//   in_ready : slave accepts in_data this cycle (slave -> master)
// A word transfers on a rising clock edge when in_valid && in_ready.
// ---------------------------------------------------------------------------
interface fpga_cfg_loader_if;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/fpga_cfg_shadow.sv
// ---------------------------------------------------------------------------
// fpga_cfg_shadow
// Payload shadow store (16 x 32) plus running XOR checksum of the words
// written into it during the current frame.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset, clears slots and checksum
//   clear_i    : start of frame, zero the checksum accumulator
//   load_i     : write data_i into slot index_i and fold it into checksum
//   index_i    : slot being written
//   data_i     : payload word
//   slots_o    : all shadow slots, slot k is payload word Pk
//   checksum_o : XOR of every word loaded since the last clear
// ---------------------------------------------------------------------------
module fpga_cfg_shadow
    import fpga_cfg_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear_i,
    input  logic                              load_i,
    input  logic [CNT_W-1:0]                  index_i,
    input  logic [WORD_W-1:0]                 data_i,
    output logic [N_PAYLOAD-1:0][WORD_W-1:0]  slots_o,
    output logic [WORD_W-1:0]                 checksum_o
);

    logic [N_PAYLOAD-1:0][WORD_W-1:0] slots_q;
    logic [WORD_W-1:0]                acc_q;
    logic [WORD_W-1:0]                acc_d;

    // Next accumulator value. Slots are not cleared at frame start because
    // every slot is rewritten before a frame can be committed.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = acc_q ^ data_i;
        end
    end

    // Shadow slots and accumulator registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            slots_q <= '0;
            acc_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_i && !clear_i) begin
                slots_q[index_i] <= data_i;
            end
        end
    end

    assign slots_o    = slots_q;
    assign checksum_o = acc_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// ---------------------------------------------------------------------------
// fpga_cfg_loader
// Receives framed configuration streams (SYNC, P0..P15, XOR checksum),
// buffers the payload in a shadow store and, when the checksum matches,
// commits it atomically to the LUT and switch-box configuration outputs.
// Ports:
//   clock       : rising-edge clock
//   reset       : synchronous active-high reset
//   stream      : valid/ready configuration word stream (slave side)
//   fabric_hold : fabric asks that no new configuration be committed yet
//   lut_cfg     : 8 x 33-bit LUT images, LUT k+1 at [33*k +: 33]
//   sb_cfg      : 7 x 32-bit switch-box words, sb k+1 at [32*k +: 32]
//   cfg_valid   : outputs hold a committed, checksum-verified frame
//   cfg_err     : one-cycle pulse on checksum mismatch
//   busy        : a frame is being loaded or checked
// ---------------------------------------------------------------------------
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT
)
(
    input  logic                     clock,
    input  logic                     reset,
    fpga_cfg_loader_if.slave         stream,
    input  logic                     fabric_hold,
    output logic [N_LUT*LUT_W-1:0]   lut_cfg,
    output logic [N_SB*SB_W-1:0]     sb_cfg,
    output logic                     cfg_valid,
    output logic                     cfg_err,
    output logic                     busy
);

    cfg_state_t                       state_q;
    logic [CNT_W-1:0]                 count_q;
    logic [N_LUT*LUT_W-1:0]           lut_q;
    logic [N_SB*SB_W-1:0]             sb_q;
    logic                             valid_q;
    logic                             err_q;
    logic                             busy_q;

    logic                             inReady;
    logic                             accept;
    logic                             shadowClear;
    logic                             shadowLoad;
    logic [N_PAYLOAD-1:0][WORD_W-1:0] slots;
    logic [WORD_W-1:0]                checksum;
    logic [N_LUT*LUT_W-1:0]           commitLut;
    logic [N_SB*SB_W-1:0]             commitSb;
    logic [23:0]                      unusedP15Low;

    // Handshake decode. in_ready is combinational so that fabric_hold stalls
    // the checksum word in the same cycle it is raised, and it is forced low
    // while reset is asserted.
    always_comb begin
        inReady = 1'b0;
        if (!reset) begin
            inReady = (state_q == CHECK) ? ~fabric_hold : 1'b1;
        end
        accept      = stream.in_valid && inReady;
        shadowClear = accept && (state_q == HUNT) && (stream.in_data == SYNC_WORD);
        shadowLoad  = accept && (state_q == LOAD);
    end

    assign stream.in_ready = inReady;

    fpga_cfg_shadow u_shadow (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (shadowClear),
        .load_i     (shadowLoad),
        .index_i    (count_q),
        .data_i     (stream.in_data),
        .slots_o    (slots),
        .checksum_o (checksum)
    );

    // Commit images built from the shadow store. The top bit of LUT k+1 comes
    // from P15[31-k]; the low 24 bits of P15 only take part in the checksum.
    always_comb begin
        commitLut = '0;
        commitSb  = '0;
        for (int k = 0; k < N_LUT; k++) begin
            commitLut[LUT_W*k +: LUT_W] = lutImage(slots[N_PAYLOAD-1][WORD_W-1-k], slots[k]);
        end
        for (int k = 0; k < N_SB; k++) begin
            commitSb[SB_W*k +: SB_W] = slots[N_LUT+k];
        end
    end

    assign unusedP15Low = slots[N_PAYLOAD-1][23:0];

    // Loader FSM with registered outputs. The committed configuration is
    // only ever replaced by a checksum-verified frame, so it stays on the
    // outputs while a later frame is loading.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HUNT;
            count_q <= '0;
            lut_q   <= '0;
            sb_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (shadowClear) begin
                        state_q <= LOAD;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        count_q <= count_q + CNT_W'(1);
                        if (count_q == CNT_W'(N_PAYLOAD - 1)) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (stream.in_data == checksum) begin
                            lut_q   <= commitLut;
                            sb_q    <= commitSb;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= HUNT;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= HUNT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lut_cfg   = lut_q;
    assign sb_cfg    = sb_q;
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have ports: clock  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_data  in  32  configuration stream word.
REQ-004 SHALL have ports: in_valid  in  1  in_data is valid this cycle.
REQ-005 SHALL have ports: in_ready  out  1  loader accepts in_data this cycle; a word transfers when in_valid && in_ready.
REQ-006 SHALL have ports: fabric_hold  in  1  fabric requests that no new configuration be committed.
REQ-007 SHALL have ports: lut_cfg  out  264  8 x 33-bit LUT images; lut_cfg[33*k +: 33] drives LUT l(k+1).
REQ-008 SHALL have ports: sb_cfg  out  224  7 x 32-bit switch-box words; sb_cfg[32*k +: 32] drives sb(k+1).
REQ-009 SHALL have ports: cfg_valid  out  1  lut_cfg/sb_cfg hold a committed, checksum-verified frame.
REQ-010 SHALL have ports: cfg_err  out  1  one-cycle pulse on checksum mismatch.
REQ-011 SHALL have ports: busy  out  1  high in LOAD or CHECK.
REQ-012 SHALL have parameter: SYNC_WORD, default 32'hF96A_C0DE, frame start marker.

Function
REQ-013 SHALL define a frame as: SYNC_WORD, then 16 payload words P0..P15, then one checksum word equal to P0^P1^...^P15.
REQ-014 SHALL implement states HUNT, LOAD, and CHECK.
REQ-015 In HUNT, SHALL drive in_ready=1, discard accepted words not equal to SYNC_WORD, and move to LOAD with word count 0 and checksum accumulator 0 on accepting SYNC_WORD.
REQ-016 In LOAD, SHALL drive in_ready=1 and store each accepted word into shadow slot [count] while XOR-ing it into the accumulator; after P15 it SHALL move to CHECK.
REQ-017 In LOAD, a word equal to SYNC_WORD SHALL be treated as ordinary payload.
REQ-018 In CHECK, SHALL drive in_ready = ~fabric_hold, so that the checksum word stalls while fabric_hold=1.
REQ-019 When the checksum word is accepted and equals the accumulator, SHALL commit at that edge as follows; outputs become visible in the next cycle, and the state returns to HUNT.
REQ-020 Commit mapping for LUTs: P(k) SHALL load lut_cfg LUT k+1 bits [31:0], and P15[31-k] SHALL load LUT k+1 bit [32], for k=0..7.
REQ-021 Commit mapping for switch boxes: P(8+k) SHALL load sb(k+1), for k=0..6.
REQ-022 Commit SHALL set cfg_valid=1; P15[23:0] SHALL be ignored for mapping but SHALL be included in the checksum.
REQ-023 On mismatch, SHALL pulse cfg_err for exactly one cycle, leave lut_cfg/sb_cfg/cfg_valid unchanged, and return to HUNT.
REQ-024 Previously committed configuration SHALL remain on the outputs, with cfg_valid=1, throughout the load of a later frame, and SHALL be replaced only at a successful commit.
REQ-025 in_valid=0 in any state SHALL hold the state and count; gaps between words are unbounded.

Reset
REQ-026 reset=1 SHALL, at the next edge, set the state to HUNT, set count, accumulator, and shadow slots to 0, set lut_cfg/sb_cfg to 0, and set cfg_valid, cfg_err, and busy to 0.
REQ-027 reset asserted mid-frame SHALL abandon that frame; the loader SHALL accept a new SYNC_WORD on the first cycle after reset deasserts.
REQ-028 While reset=1, in_ready SHALL be 0.

Structure
REQ-029 Package fpga_cfg_pkg SHALL hold SYNC_WORD default, N_LUT=8, N_SB=7, LUT_W=33, SB_W=32, N_PAYLOAD=16, and the state enum.
REQ-030 The payload shadow store and XOR accumulator SHALL be one sub-module, fpga_cfg_shadow, with load/clear/index inputs, 16x32 storage, and a running checksum output.

Verification
REQ-031 SHALL cover: reset, then SYNC, P0..P7=32'h0000_0001..8, P8..P14=32'hA5A5_0000+k, P15=32'hFF00_0000, correct checksum -> cfg_valid=1 the next cycle, LUT1=33'h1_0000_0001, sb7=32'hA5A5_0006.
REQ-032 SHALL cover: the same frame with checksum bit 0 flipped -> cfg_err pulses for one cycle, cfg_valid stays 0, and outputs stay 0.
REQ-033 SHALL cover: words 32'h1234_5678 and 32'h0 sent before SYNC -> both are discarded, and the following frame commits correctly.
REQ-034 SHALL cover: fabric_hold=1 for 5 cycles at the checksum word -> in_ready=0 for those 5 cycles, and the commit occurs on the first accept after hold drops.
REQ-035 SHALL cover: reset pulsed after P9 of a second frame -> outputs become 0 and cfg_valid=0, and a fresh full frame then commits.
REQ-036 SHALL cover: a valid frame with SYNC_WORD as P3, and in_valid gaps of 0-3 cycles -> the frame commits, and LUT4[31:0]=32'hF96A_C0DE.
